// File: rtl/mm_pkg.sv
// Shared address map and FSM state encoding for the 2x2 matrix host sequencer.
package mm_pkg;

    localparam logic [31:0] A_BASE    = 32'h00;
    localparam logic [31:0] B_BASE    = 32'h10;
    localparam logic [31:0] C_BASE    = 32'h20;
    localparam logic [31:0] CTRL_ADDR = 32'h30;
    localparam logic [31:0] STAT_ADDR = 32'h34;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_POLL_RQ,
        S_POLL_WT,
        S_CLR,
        S_RD_RQ,
        S_RD_WT,
        S_EMIT
    } state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/matrix_host_seq.sv
// Streams A,B into BRAM, kicks the accelerator, polls done, streams C back out.
// Operand writes happen in the accept cycle; results wait on res_ready (registered res_valid).
module matrix_host_seq
    import mm_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int N_ELEM     = 4,
    parameter int POLL_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] BRAM_addr,
    output logic              BRAM_clk,
    output logic [DATA_W-1:0] BRAM_din,
    input  logic [DATA_W-1:0] BRAM_dout,
    output logic              BRAM_en,
    output logic              BRAM_we
);

    localparam int N_LOAD = 2 * N_ELEM;
    localparam int LD_W   = $clog2(N_LOAD);
    localparam int RI_W   = $clog2(N_ELEM);
    localparam int PC_W   = $clog2(POLL_LIMIT + 1);

    state_t             r_state;
    state_t             w_next;
    logic [LD_W-1:0]    r_widx;
    logic [RI_W-1:0]    r_ridx;
    logic [PC_W-1:0]    r_poll;
    logic               r_clr_ph;
    logic               r_res_valid;
    logic [DATA_W-1:0]  r_res_data;
    logic               r_timeout;

    logic               w_en;
    logic               w_we;
    logic [31:0]        w_byte;
    logic [DATA_W-1:0]  w_din;
    logic               w_op_ready;
    logic               w_accept;
    logic [31:0]        w_op_addr;

    // First N_ELEM operands land in A, the rest in B.
    assign w_op_addr = (32'(r_widx) < 32'(N_ELEM))
                     ? word_addr(A_BASE, 32'(r_widx))
                     : word_addr(B_BASE, 32'(r_widx) - 32'(N_ELEM));
    assign w_accept  = op_valid & w_op_ready;

    always_comb begin
        w_next     = r_state;
        w_en       = 1'b0;
        w_we       = 1'b0;
        w_byte     = '0;
        w_din      = '0;
        w_op_ready = 1'b0;
        case (r_state)
            S_IDLE, S_LOAD: begin
                w_op_ready = 1'b1;
                if (op_valid) begin
                    w_en   = 1'b1;
                    w_we   = 1'b1;
                    w_byte = w_op_addr;
                    w_din  = op_data;
                    if (r_state == S_IDLE) begin
                        w_next = S_LOAD;
                    end else if (r_widx == LD_W'(N_LOAD - 1)) begin
                        w_next = S_START;
                    end
                end
            end
            S_START: begin
                w_en   = 1'b1;
                w_we   = 1'b1;
                w_byte = CTRL_ADDR;
                w_din  = DATA_W'(1);
                w_next = S_POLL_RQ;
            end
            S_POLL_RQ: begin
                w_en   = 1'b1;
                w_byte = STAT_ADDR;
                w_next = S_POLL_WT;
            end
            S_POLL_WT: begin
                if (BRAM_dout[0]) begin
                    w_next = S_CLR;
                end else if (r_poll == PC_W'(POLL_LIMIT - 1)) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_POLL_RQ;
                end
            end
            S_CLR: begin
                w_en   = 1'b1;
                w_we   = 1'b1;
                w_byte = r_clr_ph ? STAT_ADDR : CTRL_ADDR;
                w_next = r_clr_ph ? S_RD_RQ : S_CLR;
            end
            S_RD_RQ: begin
                w_en   = 1'b1;
                w_byte = word_addr(C_BASE, 32'(r_ridx));
                w_next = S_RD_WT;
            end
            S_RD_WT: begin
                w_next = S_EMIT;
            end
            S_EMIT: begin
                if (res_ready) begin
                    w_next = (r_ridx == RI_W'(N_ELEM - 1)) ? S_IDLE : S_RD_RQ;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_widx      <= '0;
            r_ridx      <= '0;
            r_poll      <= '0;
            r_clr_ph    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_accept) begin
                        r_widx <= (w_next == S_START) ? '0 : r_widx + 1'b1;
                        if (r_state == S_IDLE) begin
                            r_timeout <= 1'b0;
                        end
                    end
                end
                S_START: begin
                    r_poll <= '0;
                end
                S_POLL_WT: begin
                    if (!BRAM_dout[0]) begin
                        if (r_poll == PC_W'(POLL_LIMIT - 1)) begin
                            r_timeout <= 1'b1;
                            r_poll    <= '0;
                        end else begin
                            r_poll <= r_poll + 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    r_clr_ph <= ~r_clr_ph;
                    if (r_clr_ph) begin
                        r_ridx <= '0;
                    end
                end
                S_RD_WT: begin
                    r_res_data  <= BRAM_dout;
                    r_res_valid <= 1'b1;
                end
                S_EMIT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_ridx      <= r_ridx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign op_ready    = w_op_ready;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_timeout;
    assign BRAM_addr   = w_byte[ADDR_W-1:0];
    assign BRAM_clk    = clk;
    assign BRAM_din    = w_din;
    assign BRAM_en     = w_en;
    assign BRAM_we     = w_we;

endmodule

// File: doc/matrix_host_seq.md
MATRIX_HOST_SEQ -- requirements
Module: matrix_host_seq

Interface
REQ-001 Parameter ADDR_W, default 13, BRAM byte-address width.
REQ-002 Parameter DATA_W, default 32, BRAM word width.
REQ-003 Parameter N_ELEM, default 4, elements per 2x2 matrix.
REQ-004 Parameter POLL_LIMIT, default 1024, maximum status polls before timeout.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rstn  in  1  asynchronous active-low reset.
REQ-008 op_valid / op_ready / op_data  in / out / DATA_W  operand stream: A row-major (4 words), then B row-major (4 words).
REQ-009 res_valid / res_ready / res_data  out / in / DATA_W  result stream: C row-major (4 words).
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 timeout_err  out  1  sticky; set on poll timeout; cleared by reset or by the next accepted operand.
REQ-012 BRAM_addr  out  ADDR_W  byte address, always word-aligned (bits [1:0] = 0).
REQ-013 BRAM_clk  out  1  equals clk.
REQ-014 BRAM_din  out  DATA_W  write data to BRAM; BRAM_dout  in  DATA_W  read data from BRAM.
REQ-015 BRAM_en / BRAM_we  out / out  1 / 1  port enable and write enable.

Function
REQ-016 Memory map (byte addresses): A 0x00-0x0C, B 0x10-0x1C, C 0x20-0x2C, CTRL 0x30 (bit0 = start), STATUS 0x34 (bit0 = done).
REQ-017 BRAM read latency is 1 cycle: BRAM_dout is sampled the cycle after BRAM_en=1 with BRAM_we=0.
REQ-018 States: IDLE, LOAD, START, POLL_RQ, POLL_WT, CLR, RD_RQ, RD_WT, EMIT.
REQ-019 IDLE: op_ready=1; the first accepted operand is written to 0x00 in the same cycle (en=1, we=1), and the state moves to LOAD.
REQ-020 LOAD: op_ready=1; each op_valid&op_ready writes the next word (address +4) in the same cycle; after the 8th word, move to START.
REQ-021 Gaps in op_valid stall LOAD with en=0; there is no limit on gap length.
REQ-022 START: write 0x1 to 0x30 for one cycle, then go to POLL_RQ.
REQ-023 POLL_RQ: issue a read of 0x34. POLL_WT: if dout[0]=1 go to CLR; else increment poll count; at POLL_LIMIT set timeout_err and go to IDLE; otherwise go to POLL_RQ.
REQ-024 CLR: write 0x0 to 0x30 and 0x0 to 0x34 on consecutive cycles, then go to RD_RQ with index 0.
REQ-025 RD_RQ: read 0x20+4*index. RD_WT: capture dout into the result register, assert res_valid, then go to EMIT.
REQ-026 EMIT: hold res_valid and res_data stable until res_ready; on the handshake, increment index; after index 3 go to IDLE, otherwise go to RD_RQ.
REQ-027 res_valid is registered and never depends combinationally on res_ready; op_ready is high only in IDLE and LOAD.
REQ-028 Outside the defined access cycles, BRAM_en=0 and BRAM_we=0; BRAM_addr and BRAM_din are don't-care.
REQ-029 Address arithmetic is modulo 2^ADDR_W; the map never wraps at the default width.

Reset
REQ-030 When rstn=0: state=IDLE, all counters and indices = 0, res_valid=0, res_data=0, busy=0, timeout_err=0, BRAM_en=0, BRAM_we=0, BRAM_addr=0, BRAM_din=0.
REQ-031 Reset asserted mid-operation aborts immediately with no further BRAM access; a partial BRAM image is left as is.

Structure
REQ-032 Shared package mm_pkg holds the address-map localparams (A_BASE, B_BASE, C_BASE, CTRL_ADDR, STAT_ADDR) and the state enum typedef.
REQ-033 No sub-modules; a single FSM with a datapath register set.

Verification
REQ-034 Bench uses a BRAM responder model with 1-cycle read latency, plus an accelerator stub that sets STATUS=1 10 cycles after CTRL=1 and writes C = A×B.
REQ-035 Operands A=[1,2,3,4], B=[5,6,7,8] streamed back-to-back -> writes at 0x00-0x1C, CTRL write, then res_data sequence 19, 22, 43, 50.
REQ-036 op_valid toggled every other cycle -> same BRAM image; no write occurs when op_valid=0.
REQ-037 res_ready held low 5 cycles per word -> res_data stable while stalled; exactly 4 handshakes.
REQ-038 Stub never sets done, POLL_LIMIT=8 -> timeout_err=1 after 8 polls, back in IDLE, busy=0.
REQ-039 rstn pulsed low during POLL_WT -> all outputs at reset values within the same cycle; the next 8 operands complete normally.
